// File: rtl/ds2411_pkg.sv
// Shared types and constants for the DS2411 ID checker.
// Bit mapping: received bit i of the ROM image sits at rom[63-i].
package ds2411_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CRC,
    FAIL_CHK
  } state_t;

  localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;
  localparam logic [7:0] FAMILY_DS2411  = 8'h01;
  localparam int         ROM_BITS       = 64;

  // Family byte: family[k] = rom[63-k]
  function automatic logic [7:0] rom_family(input logic [ROM_BITS-1:0] rom);
    logic [7:0] res;
    for (int k = 0; k < 8; k++) res[k] = rom[63-k];
    return res;
  endfunction

  // Serial number: serial[k] = rom[55-k]
  function automatic logic [47:0] rom_serial(input logic [ROM_BITS-1:0] rom);
    logic [47:0] res;
    for (int k = 0; k < 48; k++) res[k] = rom[55-k];
    return res;
  endfunction

endpackage

// File: rtl/crc8_maxim_serial.sv
// Bit-serial Maxim/Dallas CRC-8 (x^8+x^5+x^4+1, reflected form 8'h8C).
// One input bit per enabled clock, LSB-first stream order.
module crc8_maxim_serial
  import ds2411_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_next;
  logic       fb;

  // Next CRC value for the current input bit
  always_comb begin
    fb       = crc_q[0] ^ bit_in;
    crc_next = (crc_q >> 1) ^ (fb ? CRC8_POLY_REFL : 8'h00);
  end

  // CRC register: synchronous clear wins over update
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    crc_q <= 8'h00;
    else if (clr) crc_q <= 8'h00;
    else if (en)  crc_q <= crc_next;
  end

  assign crc = crc_q;

endmodule

// File: rtl/ds2411_id_check.sv
// DS2411 ID checker: drives the reader's go handshake, validates the ROM
// image (CRC-8 and family byte), retries, and latches the serial number.
// Optional build macro: DS2411_ERR_COUNT_EN enables the error counters;
// without it crc_err_count and nodev_count read 0.
//
// Reader handshake: go_out is held high until the synchronised working
// input is seen high; an attempt ends on the synchronised falling edge of
// working, at which point done/error (synchronised with the same latency)
// qualify the result. rom_in must be stable across that edge.
//
// attempts counts started attempts in the current sequence (saturating at
// 7), so MAX_RETRY must be 6 or less for the retry limit to be reachable.
module ds2411_id_check
  import ds2411_pkg::*;
#(
  parameter logic [7:0] FAMILY_CODE = FAMILY_DS2411,
  parameter int         MAX_RETRY   = 3,
  parameter int         REQ_TIMEOUT = 1000,
  parameter int         AUTO_START  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                go_out,
  input  logic [ROM_BITS-1:0] rom_in,
  input  logic                working_in,
  input  logic                done_in,
  input  logic                error_in,
  output logic                busy,
  output logic                id_valid,
  output logic                id_fail,
  output logic [47:0]         serial_number,
  output logic [7:0]          family_code,
  output logic [2:0]          attempts,
  output logic [7:0]          crc_err_count,
  output logic [7:0]          nodev_count,
  output state_t              state_dbg
);

  localparam int TW = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;

  // Synchroniser chain: bit 0 working, bit 1 done, bit 2 error
  logic [2:0] sync1_q, sync2_q;
  logic       work_d_q;
  logic       work_s, done_s, err_s, work_fall;

  state_t              state_q, state_d;
  logic                go_q, go_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                fail_q, fail_d;
  logic [2:0]          attempts_q, attempts_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [6:0]          bit_cnt_q, bit_cnt_d;
  logic [ROM_BITS-1:0] rom_sh_q, rom_sh_d;
  logic [7:0]          fam_q, fam_d;
  logic [47:0]         ser_q, ser_d;
  logic                auto_pend_q;

  logic       crc_clr, crc_en, crc_bit;
  logic [7:0] crc;
  logic       timeout_hit, crc_done, id_good;
  logic [7:0] fam_rx;
  logic [47:0] ser_rx;

  // Two-flop synchronisers plus a delayed working for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 3'b000;
      sync2_q  <= 3'b000;
      work_d_q <= 1'b0;
    end else begin
      sync1_q  <= {error_in, done_in, working_in};
      sync2_q  <= sync1_q;
      work_d_q <= sync2_q[0];
    end
  end

  assign work_s    = sync2_q[0];
  assign done_s    = sync2_q[1];
  assign err_s     = sync2_q[2];
  assign work_fall = work_d_q & ~work_s;

  assign timeout_hit = (timer_q == TW'(REQ_TIMEOUT - 1));
  assign crc_done    = bit_cnt_q[6];
  assign crc_bit     = rom_sh_q[~bit_cnt_q[5:0]];
  assign fam_rx      = rom_family(rom_sh_q);
  assign ser_rx      = rom_serial(rom_sh_q);
  assign id_good     = (crc == 8'h00) && (fam_rx == FAMILY_CODE);

  crc8_maxim_serial u_crc (
    .clk    (clk),
    .reset  (reset),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  // Next-state and next-register values
  always_comb begin
    state_d    = state_q;
    go_d       = go_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    fail_d     = fail_q;
    attempts_d = attempts_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    rom_sh_d   = rom_sh_q;
    fam_d      = fam_q;
    ser_d      = ser_q;
    crc_clr    = 1'b1;
    crc_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start || auto_pend_q) begin
          valid_d    = 1'b0;
          fail_d     = 1'b0;
          attempts_d = 3'd1;
          busy_d     = 1'b1;
          go_d       = 1'b1;
          timer_d    = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (work_s) begin
          go_d    = 1'b0;
          state_d = WAIT;
        end else if (timeout_hit) begin
          go_d    = 1'b0;
          state_d = FAIL_CHK;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT: begin
        if (work_fall) begin
          if (err_s || !done_s) begin
            state_d = FAIL_CHK;
          end else begin
            rom_sh_d  = rom_in;
            bit_cnt_d = '0;
            state_d   = CRC;
          end
        end
      end
      CRC: begin
        crc_clr = 1'b0;
        if (!crc_done) begin
          crc_en    = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (id_good) begin
          fam_d   = fam_rx;
          ser_d   = ser_rx;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = FAIL_CHK;
        end
      end
      FAIL_CHK: begin
        if (int'(attempts_q) > MAX_RETRY) begin
          fail_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          attempts_d = (attempts_q == 3'd7) ? 3'd7 : attempts_q + 1'b1;
          go_d       = 1'b1;
          timer_d    = '0;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      go_q        <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      fail_q      <= 1'b0;
      attempts_q  <= 3'd0;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      rom_sh_q    <= '0;
      fam_q       <= 8'h00;
      ser_q       <= 48'h0;
      auto_pend_q <= (AUTO_START != 0);
    end else begin
      state_q     <= state_d;
      go_q        <= go_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      fail_q      <= fail_d;
      attempts_q  <= attempts_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      rom_sh_q    <= rom_sh_d;
      fam_q       <= fam_d;
      ser_q       <= ser_d;
      auto_pend_q <= 1'b0;
    end
  end

`ifdef DS2411_ERR_COUNT_EN
  logic       crc_fail_ev, nodev_ev;
  logic [7:0] crc_err_q, nodev_q;

  assign crc_fail_ev = (state_q == CRC) && crc_done && !id_good;
  assign nodev_ev    = ((state_q == REQ) && !work_s && timeout_hit) ||
                       ((state_q == WAIT) && work_fall && err_s);

  // Saturating failure counters, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_err_q <= 8'h00;
      nodev_q   <= 8'h00;
    end else begin
      if (crc_fail_ev && crc_err_q != 8'hFF) crc_err_q <= crc_err_q + 1'b1;
      if (nodev_ev && nodev_q != 8'hFF)      nodev_q   <= nodev_q + 1'b1;
    end
  end

  assign crc_err_count = crc_err_q;
  assign nodev_count   = nodev_q;
`else
  assign crc_err_count = 8'h00;
  assign nodev_count   = 8'h00;
`endif

  assign go_out        = go_q;
  assign busy          = busy_q;
  assign id_valid      = valid_q;
  assign id_fail       = fail_q;
  assign attempts      = attempts_q;
  assign family_code   = fam_q;
  assign serial_number = ser_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_ds2411_id_check.sv
// Directed bench for ds2411_id_check. dut_a expects family 0x02 (the test
// image), dut_b expects 0x01 so the same image fails on family only.
// Each DUT has its own reader-side handshake lines; the ROM bus is shared.
module tb_ds2411_id_check;
  import ds2411_pkg::*;

  localparam int TMO = 20;
  localparam logic [63:0] GOOD_ROM = 64'h40381D8000000045;
  localparam logic [47:0] GOOD_SER = 48'h00000001B81C;
`ifdef DS2411_ERR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [63:0] rom;
  logic [1:0]  st, wk, dn, er;
  logic [1:0]  go, busy_v, valid_v, fail_v;
  logic [47:0] ser_a, ser_b;
  logic [7:0]  fam_a, fam_b;
  logic [2:0]  att_a, att_b;
  logic [7:0]  crc_cnt_a, crc_cnt_b, nodev_a, nodev_b;
  state_t      dbg_a, dbg_b;

  int n_total = 0;
  int n_bad   = 0;

  ds2411_id_check #(.FAMILY_CODE(8'h02), .MAX_RETRY(3), .REQ_TIMEOUT(TMO), .AUTO_START(1)) dut_a (
    .clk(clk), .reset(reset), .start(st[0]), .go_out(go[0]), .rom_in(rom),
    .working_in(wk[0]), .done_in(dn[0]), .error_in(er[0]), .busy(busy_v[0]),
    .id_valid(valid_v[0]), .id_fail(fail_v[0]), .serial_number(ser_a),
    .family_code(fam_a), .attempts(att_a), .crc_err_count(crc_cnt_a),
    .nodev_count(nodev_a), .state_dbg(dbg_a)
  );

  ds2411_id_check #(.FAMILY_CODE(8'h01), .MAX_RETRY(3), .REQ_TIMEOUT(TMO), .AUTO_START(1)) dut_b (
    .clk(clk), .reset(reset), .start(st[1]), .go_out(go[1]), .rom_in(rom),
    .working_in(wk[1]), .done_in(dn[1]), .error_in(er[1]), .busy(busy_v[1]),
    .id_valid(valid_v[1]), .id_fail(fail_v[1]), .serial_number(ser_b),
    .family_code(fam_b), .attempts(att_b), .crc_err_count(crc_cnt_b),
    .nodev_count(nodev_b), .state_dbg(dbg_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk); st[d] = 1'b1;
    @(negedge clk); st[d] = 1'b0;
  endtask

  // Reader model: answer one go request, ending with done or error
  task automatic serve(input int d, input logic err_flag);
    int n;
    n = 0;
    while (go[d] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (go[d] !== 1'b1) begin
      chk("serve_go_seen", {63'd0, go[d]}, 64'd1);
      return;
    end
    dn[d] = 1'b0;
    er[d] = 1'b0;
    repeat (3) @(negedge clk);
    wk[d] = 1'b1;
    n = 0;
    while (go[d] === 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    dn[d] = ~err_flag;
    er[d] = err_flag;
    wk[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n;
    n = 0;
    while (busy_v[d] === 1'b1 && n < budget) begin @(negedge clk); n++; end
    if (busy_v[d] !== 1'b0) chk("idle_reached", {63'd0, busy_v[d]}, 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    rom   = GOOD_ROM;
    st = '0; wk = '0; dn = '0; er = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_go",       {63'd0, go[0]},      64'd0);
    chk("rst_busy",     {63'd0, busy_v[0]},  64'd0);
    chk("rst_valid",    {63'd0, valid_v[0]}, 64'd0);
    chk("rst_fail",     {63'd0, fail_v[0]},  64'd0);
    chk("rst_serial",   {16'd0, ser_a},      64'd0);
    chk("rst_family",   {56'd0, fam_a},      64'd0);
    chk("rst_attempts", {61'd0, att_a},      64'd0);

    // Auto start one cycle after release
    reset = 1'b0;
    @(negedge clk);
    chk("auto_busy", {63'd0, busy_v[0]}, 64'd1);
    chk("auto_go",   {63'd0, go[0]},     64'd1);

    // Good image, first attempt
    serve(0, 1'b0);
    wait_idle(0, 300);
    chk("good_valid",    {63'd0, valid_v[0]}, 64'd1);
    chk("good_fail",     {63'd0, fail_v[0]},  64'd0);
    chk("good_serial",   {16'd0, ser_a},      {16'd0, GOOD_SER});
    chk("good_family",   {56'd0, fam_a},      64'h02);
    chk("good_attempts", {61'd0, att_a},      64'd1);

    // CRC-bad image on every attempt; a start while busy is ignored
    rom = GOOD_ROM ^ 64'd1;
    pulse_start(0);
    serve(0, 1'b0);
    serve(0, 1'b0);
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    chk("busy_start_att",  {61'd0, att_a},     64'd2);
    chk("busy_start_busy", {63'd0, busy_v[0]}, 64'd1);
    serve(0, 1'b0);
    serve(0, 1'b0);
    wait_idle(0, 300);
    chk("crcbad_fail",     {63'd0, fail_v[0]},  64'd1);
    chk("crcbad_valid",    {63'd0, valid_v[0]}, 64'd0);
    chk("crcbad_attempts", {61'd0, att_a},      64'd4);
    chk("crcbad_serial",   {16'd0, ser_a},      {16'd0, GOOD_SER});
    chk("crcbad_cnt",      {56'd0, crc_cnt_a},  CNT_EN ? 64'd4 : 64'd0);

    // No-presence error, then good
    rom = GOOD_ROM;
    pulse_start(0);
    serve(0, 1'b1);
    serve(0, 1'b0);
    wait_idle(0, 300);
    chk("err1_valid",    {63'd0, valid_v[0]}, 64'd1);
    chk("err1_attempts", {61'd0, att_a},      64'd2);
    chk("err1_nodev",    {56'd0, nodev_a},    CNT_EN ? 64'd1 : 64'd0);

    // Reader never responds: go high for exactly TMO cycles per attempt
    pulse_start(0);
    n = 0;
    while (go[0] === 1'b1 && n < 100) begin n++; @(negedge clk); end
    chk("tmo_go_cycles", 64'(n), 64'(TMO));
    wait_idle(0, 400);
    chk("tmo_fail",     {63'd0, fail_v[0]},  64'd1);
    chk("tmo_valid",    {63'd0, valid_v[0]}, 64'd0);
    chk("tmo_attempts", {61'd0, att_a},      64'd4);
    chk("tmo_nodev",    {56'd0, nodev_a},    CNT_EN ? 64'd5 : 64'd0);
    chk("tmo_crc_cnt",  {56'd0, crc_cnt_a},  CNT_EN ? 64'd4 : 64'd0);

    // Family mismatch on dut_b: CRC good, family 0x02 != 0x01
    wait_idle(1, 400);
    pulse_start(1);
    for (int i = 0; i < 4; i++) serve(1, 1'b0);
    wait_idle(1, 300);
    chk("fam_fail",     {63'd0, fail_v[1]},  64'd1);
    chk("fam_valid",    {63'd0, valid_v[1]}, 64'd0);
    chk("fam_attempts", {61'd0, att_b},      64'd4);
    chk("fam_family",   {56'd0, fam_b},      64'd0);
    chk("fam_crc_cnt",  {56'd0, crc_cnt_b},  CNT_EN ? 64'd4 : 64'd0);
    chk("fam_nodev",    {56'd0, nodev_b},    CNT_EN ? 64'd4 : 64'd0);

    // Reset in the middle of the CRC walk
    pulse_start(0);
    serve(0, 1'b0);
    repeat (20) @(negedge clk);
    chk("midcrc_busy_pre", {63'd0, busy_v[0]}, 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_busy",     {63'd0, busy_v[0]},  64'd0);
    chk("midrst_go",       {63'd0, go[0]},      64'd0);
    chk("midrst_valid",    {63'd0, valid_v[0]}, 64'd0);
    chk("midrst_serial",   {16'd0, ser_a},      64'd0);
    chk("midrst_family",   {56'd0, fam_a},      64'd0);
    chk("midrst_attempts", {61'd0, att_a},      64'd0);
    chk("midrst_nodev",    {56'd0, nodev_a},    64'd0);
    chk("midrst_crc_cnt",  {56'd0, crc_cnt_a},  64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulse_start(0);
    serve(0, 1'b0);
    wait_idle(0, 300);
    chk("post_valid",    {63'd0, valid_v[0]}, 64'd1);
    chk("post_serial",   {16'd0, ser_a},      {16'd0, GOOD_SER});
    chk("post_family",   {56'd0, fam_a},      64'h02);
    chk("post_attempts", {61'd0, att_a},      64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
